// File: rtl/rev_lookup_engine_pkg.sv
// -----------------------------------------------------------------------------
// rev_lookup_engine_pkg
//   Shared definitions for the reverse lookup engine.
//   - DEF_A / DEF_D / DEF_DEPTH : default key width, payload width, entry count
//   - state_e                   : FSM state codes (2-bit, S0..S3)
// -----------------------------------------------------------------------------
package rev_lookup_engine_pkg;

    localparam int DEF_A     = 8;
    localparam int DEF_D     = 8;
    localparam int DEF_DEPTH = 128;

    typedef enum logic [1:0] {
        S0_IDLE = 2'b00,
        S1_SCAN = 2'b01,
        S2_HIT  = 2'b10,
        S3_MISS = 2'b11
    } state_e;

endpackage : rev_lookup_engine_pkg

// File: rtl/rev_lookup_engine_entry_ram.sv
// -----------------------------------------------------------------------------
// entry_ram
//   Single-port DEPTH x W storage for (key, payload) entries.
//   Synchronous write and synchronous read with one cycle of read latency.
//   Ports:
//     clk_i    : clock
//     ce_i     : port enable; nothing happens when low
//     we_i     : 1 = write wdata_i at addr_i, 0 = read addr_i into rdata_o
//     addr_i   : entry index
//     wdata_i  : entry to store
//     rdata_o  : entry read on the previous enabled read cycle (held otherwise)
// -----------------------------------------------------------------------------
module entry_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 128,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          ce_i,
    input  logic          we_i,
    input  logic [IW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the
    // entry count in the engine.
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule : entry_ram

// File: rtl/rev_lookup_engine.sv
// -----------------------------------------------------------------------------
// rev_lookup_engine
//   Append-only table of (key, payload) entries with a reverse lookup: a query
//   scans indices 0..count-1 and returns the payload of the lowest-index entry
//   whose key matches.
//   Ports:
//     clk, rst (async, active-low)
//     wr_en / wr_addr / wr_data : append one entry (IDLE and not full only)
//     clr                       : zero the entry count (IDLE only, beats wr_en)
//     qry_valid / qry_addr      : query request, accepted in IDLE only
//     busy                      : state is not IDLE
//     full / count              : entry occupancy
//     rd_valid                  : one-cycle result strobe
//     rd_hit / rd_data / rd_index : result, held between strobes
//     dbg_state                 : current FSM state
//
//   Handshake: qry_valid is sampled only while busy=0; the requester holds it
//   until then. One query is in flight at a time and its result appears as a
//   single rd_valid pulse; there is no backpressure on the result.
//
//   Timing: the RAM read of index 0 is issued in the accepting IDLE cycle, so
//   index k is compared k+1 cycles after acceptance. When a write shares the
//   accepting cycle the RAM port is taken by the write and the first read is
//   issued from SCAN instead, adding one cycle to that query only.
// -----------------------------------------------------------------------------
module rev_lookup_engine
    import rev_lookup_engine_pkg::*;
#(
    parameter int A     = DEF_A,
    parameter int D     = DEF_D,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [A-1:0]                 wr_addr,
    input  logic [D-1:0]                 wr_data,
    input  logic                         clr,
    input  logic                         qry_valid,
    input  logic [A-1:0]                 qry_addr,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         rd_valid,
    output logic                         rd_hit,
    output logic [D-1:0]                 rd_data,
    output logic [$clog2(DEPTH)-1:0]     rd_index,
    output state_e                       dbg_state
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = A + D;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   limit_q, limit_d;     // count captured at query accept
    logic [A-1:0]    key_q, key_d;
    logic [CW-1:0]   issue_q, issue_d;     // next index to read
    logic            cmp_valid_q, cmp_valid_d;  // RAM output holds a fresh entry
    logic [IW-1:0]   cmp_idx_q, cmp_idx_d;  // index of that entry
    logic            rd_hit_q, rd_hit_d;
    logic [D-1:0]    rd_data_q, rd_data_d;
    logic [IW-1:0]   rd_index_q, rd_index_d;

    logic            ram_ce, ram_we;
    logic [IW-1:0]   ram_addr;
    logic [W-1:0]    ram_wdata, ram_rdata;
    logic [A-1:0]    ram_key;
    logic [D-1:0]    ram_data;
    logic            full_w;

    assign full_w   = (count_q == CW'(DEPTH));
    assign ram_key  = ram_rdata[W-1:D];
    assign ram_data = ram_rdata[D-1:0];

    entry_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_entry_ram (
        .clk_i   (clk),
        .ce_i    (ram_ce),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        key_d       = key_q;
        issue_d     = issue_q;
        cmp_valid_d = 1'b0;
        cmp_idx_d   = cmp_idx_q;
        rd_hit_d    = rd_hit_q;
        rd_data_d   = rd_data_q;
        rd_index_d  = rd_index_q;
        ram_ce      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = {wr_addr, wr_data};

        case (state_q)
            S0_IDLE: begin
                if (clr) begin
                    count_d = '0;
                end else if (wr_en && !full_w) begin
                    ram_ce   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = count_q[IW-1:0];
                    count_d  = count_q + CW'(1);
                end

                if (qry_valid) begin
                    key_d   = qry_addr;
                    limit_d = count_q;   // pre-write / pre-clear count
                    issue_d = '0;
                    if (count_q == '0) begin
                        state_d    = S3_MISS;
                        rd_hit_d   = 1'b0;
                        rd_data_d  = '0;
                        rd_index_d = '0;
                    end else begin
                        state_d = S1_SCAN;
                        // Prefetch index 0 unless the write owns the port.
                        if (!ram_we) begin
                            ram_ce      = 1'b1;
                            ram_addr    = '0;
                            issue_d     = CW'(1);
                            cmp_valid_d = 1'b1;
                            cmp_idx_d   = '0;
                        end
                    end
                end
            end

            S1_SCAN: begin
                if (issue_q < limit_q) begin
                    ram_ce      = 1'b1;
                    ram_addr    = issue_q[IW-1:0];
                    issue_d     = issue_q + CW'(1);
                    cmp_valid_d = 1'b1;
                    cmp_idx_d   = issue_q[IW-1:0];
                end

                if (cmp_valid_q) begin
                    if (ram_key == key_q) begin
                        state_d    = S2_HIT;
                        rd_hit_d   = 1'b1;
                        rd_data_d  = ram_data;
                        rd_index_d = cmp_idx_q;
                    end else if ((CW'(cmp_idx_q) + CW'(1)) == limit_q) begin
                        state_d    = S3_MISS;
                        rd_hit_d   = 1'b0;
                        rd_data_d  = '0;
                        rd_index_d = '0;
                    end
                end
            end

            S2_HIT, S3_MISS: begin
                state_d = S0_IDLE;
            end

            default: begin
                state_d = S0_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S0_IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            key_q       <= '0;
            issue_q     <= '0;
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            rd_hit_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            key_q       <= key_d;
            issue_q     <= issue_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_idx_q   <= cmp_idx_d;
            rd_hit_q    <= rd_hit_d;
            rd_data_q   <= rd_data_d;
            rd_index_q  <= rd_index_d;
        end
    end

    assign busy      = (state_q != S0_IDLE);
    assign full      = full_w;
    assign count     = count_q;
    assign rd_valid  = (state_q == S2_HIT) || (state_q == S3_MISS);
    assign rd_hit    = rd_hit_q;
    assign rd_data   = rd_data_q;
    assign rd_index  = rd_index_q;
    assign dbg_state = state_q;

endmodule : rev_lookup_engine

// File: tb/tb_rev_lookup_engine.sv
// -----------------------------------------------------------------------------
// tb_rev_lookup_engine
//   Scenario tasks drive writes/queries; every query pushes its expected
//   {hit, data, index} into exp_q and a negedge monitor pops and compares on
//   each rd_valid strobe. Latencies and status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_rev_lookup_engine;
    import rev_lookup_engine_pkg::*;

    localparam int A  = 8;
    localparam int D  = 8;
    localparam int EW = 1 + D + 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [D-1:0] wr_data = '0;
    logic         clr = 1'b0;
    logic         qry_valid = 1'b0;
    logic [A-1:0] qry_addr = '0;
    logic         busy, full, rd_valid, rd_hit;
    logic [7:0]   count;
    logic [D-1:0] rd_data;
    logic [6:0]   rd_index;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    rev_lookup_engine dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr       (clr),
        .qry_valid (qry_valid),
        .qry_addr  (qry_addr),
        .busy      (busy),
        .full      (full),
        .count     (count),
        .rd_valid  (rd_valid),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .rd_index  (rd_index),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid: got hit=%0b data=%0h index=%0d, want no strobe",
                         rd_hit, rd_data, rd_index);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rd_hit, rd_data, rd_index} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got hit=%0b data=%0h index=%0d, want hit=%0b data=%0h index=%0d",
                             rd_hit, rd_data, rd_index, mon_e[EW-1], mon_e[EW-2:7], mon_e[6:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [A-1:0] a, input logic [D-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Edges counted from the accepting edge (that edge counts as 1).
    task automatic wait_result(output int lat);
        lat = 1;
        while (rd_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rd_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL query_timeout: got no rd_valid in %0d edges, want a strobe", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_query(input logic [A-1:0] key, input logic eh, input logic [D-1:0] ed,
                              input logic [6:0] ei, output int lat);
        exp_q.push_back({eh, ed, ei});
        qry_valid = 1'b1; qry_addr = key;
        @(posedge clk); #1;
        qry_valid = 1'b0;
        wait_result(lat);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        checks++; if ({rd_hit, rd_data, rd_index} !== '0) begin errors++;
            $display("FAIL reset_result: got hit=%0b data=%0h index=%0d want all 0", rd_hit, rd_data, rd_index); end
        checks++; if (dbg_state !== S0_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        int lat;
        exp_q.push_back('0);
        qry_valid = 1'b1; qry_addr = 8'h10;
        @(posedge clk); #1;
        qry_valid = 1'b0;
        checks++; if (rd_valid !== 1'b1 || busy !== 1'b1 || dbg_state !== S3_MISS) begin errors++;
            $display("FAIL empty_strobe: got rd_valid=%0b busy=%0b state=%0d want 1 1 3", rd_valid, busy, dbg_state); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++;
            $display("FAIL empty_busy_len: got busy=%0b rd_valid=%0b want 0 0", busy, rd_valid); end
        send_query(8'h20, 1'b0, 8'h00, 7'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency: got %0d want 1", lat); end
    endtask

    task automatic test_basic();
        int lat;
        do_write(8'h10, 8'hA1);
        do_write(8'h20, 8'hB2);
        do_write(8'h30, 8'hC3);
        checks++; if (count !== 8'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
        send_query(8'h30, 1'b1, 8'hC3, 7'd2, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hit2_latency: got %0d want 4", lat); end
        checks++; if (rd_valid !== 1'b0 || rd_hit !== 1'b1 || rd_data !== 8'hC3 || rd_index !== 7'd2) begin errors++;
            $display("FAIL result_hold: got v=%0b hit=%0b data=%0h idx=%0d want 0 1 c3 2", rd_valid, rd_hit, rd_data, rd_index); end
        send_query(8'h55, 1'b0, 8'h00, 7'd0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL miss3_latency: got %0d want 4", lat); end
        send_query(8'h10, 1'b1, 8'hA1, 7'd0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit0_latency: got %0d want 2", lat); end
    endtask

    // Write and query in the same IDLE cycle: query sees the pre-write count.
    task automatic test_same_cycle();
        int lat;
        exp_q.push_back('0);
        wr_en = 1'b1; wr_addr = 8'h66; wr_data = 8'h77;
        qry_valid = 1'b1; qry_addr = 8'h66;
        @(posedge clk); #1;
        wr_en = 1'b0; qry_valid = 1'b0;
        wait_result(lat);
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL same_cycle_count: got %0d want 4", count); end
        send_query(8'h66, 1'b1, 8'h77, 7'd3, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL hit3_latency: got %0d want 5", lat); end
    endtask

    // wr_en and clr while busy are ignored.
    task automatic test_busy_ignore();
        int lat;
        exp_q.push_back('0);
        qry_valid = 1'b1; qry_addr = 8'h55;
        @(posedge clk); #1;
        qry_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_scan: got %0b want 1", busy); end
        wr_en = 1'b1; wr_addr = 8'h55; wr_data = 8'h99; clr = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; clr = 1'b0;
        wait_result(lat);
        lat = lat + 1;
        checks++; if (lat !== 5) begin errors++; $display("FAIL miss4_latency: got %0d want 5", lat); end
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL busy_ignore_count: got %0d want 4", count); end
    endtask

    task automatic test_duplicates();
        int lat;
        do_clr();
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count); end
        do_write(8'h44, 8'h01);
        do_write(8'h44, 8'h02);
        send_query(8'h44, 1'b1, 8'h01, 7'd0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dup_latency: got %0d want 2", lat); end
        // Index 2 still holds the old 0x30 entry but lies beyond count.
        send_query(8'h30, 1'b0, 8'h00, 7'd0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL stale_latency: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        logic [A-1:0] mk[$];
        logic [D-1:0] md[$];
        logic [A-1:0] key, k;
        logic [D-1:0] d, ed;
        logic [6:0]   ei;
        logic         eh;
        int n, lat, exp_lat;
        do_clr();
        n = $urandom_range(20, 1);
        for (int i = 0; i < n; i++) begin
            k = 8'($urandom_range(7, 0));
            d = 8'($urandom_range(255, 0));
            do_write(k, d);
            mk.push_back(k);
            md.push_back(d);
        end
        for (int q = 0; q < 10; q++) begin
            key = 8'($urandom_range(9, 0));
            eh = 1'b0; ed = '0; ei = '0; exp_lat = n + 1;
            for (int i = n - 1; i >= 0; i--) begin
                if (mk[i] == key) begin
                    eh = 1'b1; ed = md[i]; ei = 7'(i); exp_lat = i + 2;
                end
            end
            send_query(key, eh, ed, ei, lat);
            checks++; if (lat !== exp_lat) begin errors++;
                $display("FAIL random_latency: key=%0h got %0d want %0d", key, lat, exp_lat); end
        end
    endtask

    task automatic test_full();
        int lat;
        do_clr();
        for (int i = 0; i < 128; i++) begin
            do_write(8'(i), 8'(i) ^ 8'h5A);
        end
        checks++; if (count !== 8'd128 || full !== 1'b1) begin errors++;
            $display("FAIL full_status: got count=%0d full=%0b want 128 1", count, full); end
        do_write(8'hFF, 8'hEE);
        checks++; if (count !== 8'd128 || full !== 1'b1) begin errors++;
            $display("FAIL full_write_ignored: got count=%0d full=%0b want 128 1", count, full); end
        send_query(8'hFF, 1'b0, 8'h00, 7'd0, lat);
        checks++; if (lat !== 129) begin errors++; $display("FAIL miss128_latency: got %0d want 129", lat); end
        send_query(8'h7F, 1'b1, 8'h25, 7'd127, lat);
        checks++; if (lat !== 129) begin errors++; $display("FAIL hit127_latency: got %0d want 129", lat); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        do_clr();
        for (int i = 0; i < 100; i++) begin
            do_write(8'(i), 8'(i));
        end
        qry_valid = 1'b1; qry_addr = 8'hFE;
        @(posedge clk); #1;
        qry_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_scan_busy: got %0b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if ({busy, full, rd_valid, rd_hit} !== 4'b0 || count !== 8'd0 || rd_data !== 8'd0 || rd_index !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b full=%0b v=%0b hit=%0b count=%0d data=%0h idx=%0d want all 0",
                     busy, full, rd_valid, rd_hit, count, rd_data, rd_index);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (dbg_state !== S0_IDLE || busy !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle: got state=%0d busy=%0b want 0 0", dbg_state, busy); end
        repeat (120) @(posedge clk);
        #1;
        do_write(8'h99, 8'h11);
        do_write(8'h98, 8'h12);
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL post_reset_count: got %0d want 2", count); end
        clr = 1'b1; wr_en = 1'b1; wr_addr = 8'h97; wr_data = 8'h13;
        @(posedge clk); #1;
        clr = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL clr_over_wr: got %0d want 0", count); end
        send_query(8'h99, 1'b0, 8'h00, 7'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL clr_empty_latency: got %0d want 1", lat); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_empty();
        test_basic();
        test_same_cycle();
        test_busy_ignore();
        test_duplicates();
        test_random();
        test_full();
        test_reset_mid_scan();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rev_lookup_engine
